// File: rtl/memory_address_pkg.sv
// Shared phase/address-mode types, default mode masks and a log helper
// for the address-mode sequencer and the disassembler.
package memory_address_pkg;

  typedef enum logic [1:0] {PH_FETCH, PH_DECODE, PH_EXEC} phase_e;
  typedef enum logic [1:0] {AM_PC, AM_REG, AM_DIR, AM_IDX} amode_e;

  localparam int unsigned DEF_CTRL_W   = 3;
  localparam logic [7:0]  DEF_REG_MASK = 8'b0000_0101;
  localparam logic [7:0]  DEF_DIR_MASK = 8'b0111_0000;
  localparam logic [7:0]  DEF_PC_MASK  = 8'b0000_0010;
`ifdef SPAM_AMODE_INDEXED_EN
  localparam logic [7:0]  DEF_IDX_MASK = 8'b1000_0000;
`endif

  function automatic string fAmodeStr(amode_e m);
    case (m)
      AM_PC:   return "pc";
      AM_REG:  return "reg";
      AM_DIR:  return "dir";
      default: return "idx";
    endcase
  endfunction

endpackage

// File: rtl/amode_lookup.sv
// Combinational control-code to address-mode lookup; shared with the
// disassembler. Indexed mode exists only when SPAM_AMODE_INDEXED_EN is defined.
module amode_lookup
  import memory_address_pkg::*;
#(
  parameter int unsigned          CTRL_W   = DEF_CTRL_W,
  parameter logic [2**CTRL_W-1:0] REG_MASK = DEF_REG_MASK,
  parameter logic [2**CTRL_W-1:0] DIR_MASK = DEF_DIR_MASK,
  parameter logic [2**CTRL_W-1:0] PC_MASK  = DEF_PC_MASK
`ifdef SPAM_AMODE_INDEXED_EN
  , parameter logic [2**CTRL_W-1:0] IDX_MASK = DEF_IDX_MASK
`endif
) (
  input  logic [CTRL_W-1:0] code_i,
  output amode_e            amode_o,
  output logic              illegal_o
);

  // Register and direct take priority; a code in no mask falls back to PC.
  always_comb begin
    amode_o   = AM_PC;
    illegal_o = 1'b0;
    if (REG_MASK[code_i])      amode_o = AM_REG;
    else if (DIR_MASK[code_i]) amode_o = AM_DIR;
`ifdef SPAM_AMODE_INDEXED_EN
    else if (IDX_MASK[code_i]) amode_o = AM_IDX;
`endif
    else if (!PC_MASK[code_i]) illegal_o = 1'b1;
  end

endmodule

// File: rtl/memory_address_sequencer.sv
// Fetch/decode/exec sequencer driving registered, one-hot active-low address
// bus enables. Define SPAM_AMODE_INDEXED_EN to add the indexed (MAR+IR) mode.
module memory_address_sequencer
  import memory_address_pkg::*;
#(
  parameter int unsigned          CTRL_W      = DEF_CTRL_W,
  parameter logic [2**CTRL_W-1:0] REG_MASK    = DEF_REG_MASK,
  parameter logic [2**CTRL_W-1:0] DIR_MASK    = DEF_DIR_MASK,
  parameter logic [2**CTRL_W-1:0] PC_MASK     = DEF_PC_MASK,
  parameter int unsigned          EXEC_CYCLES = 1,
  parameter int unsigned          WAIT_STATES = 0,
  parameter int unsigned          LOG         = 1
`ifdef SPAM_AMODE_INDEXED_EN
  , parameter logic [2**CTRL_W-1:0] IDX_MASK  = DEF_IDX_MASK
`endif
) (
  input  logic              clk,
  input  logic              mr,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              mem_rdy,
  output logic              phaseFetch,
  output logic              phaseDecode,
  output logic              phaseExec,
  output logic              _phaseFetch,
  output logic              _addrmode_pc,
  output logic              _addrmode_register,
  output logic              _addrmode_direct,
`ifdef SPAM_AMODE_INDEXED_EN
  output logic              _addrmode_indexed,
`endif
  output logic              illegal_mode,
  output logic [CTRL_W-1:0] ctrl_q
);

  generate
    if ((REG_MASK & DIR_MASK) != '0) begin : g_err_mask_overlap
      $error("REG_MASK and DIR_MASK overlap");
    end
`ifdef SPAM_AMODE_INDEXED_EN
    if (((REG_MASK | DIR_MASK) & IDX_MASK) != '0) begin : g_err_idx_overlap
      $error("IDX_MASK overlaps REG_MASK or DIR_MASK");
    end
`endif
    if (EXEC_CYCLES < 1 || EXEC_CYCLES > 4) begin : g_err_exec
      $error("EXEC_CYCLES must be 1..4");
    end
    if (WAIT_STATES > 7) begin : g_err_wait
      $error("WAIT_STATES must be 0..7");
    end
    if (LOG > 1) begin : g_err_log
      $error("LOG must be 0 or 1");
    end
  endgenerate

  localparam logic [2:0] WAIT_MAX  = 3'(WAIT_STATES);
  localparam logic [1:0] EXEC_LAST = 2'(EXEC_CYCLES - 1);

  phase_e            state_q, state_d;
  logic [2:0]        wait_q, wait_d;
  logic [1:0]        exec_q, exec_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic              phase_done;

  logic pf_q, pd_q, pe_q, npf_q;
  logic pc_n_q, pc_n_d, reg_n_q, reg_n_d, dir_n_q, dir_n_d;
  logic illegal_q, illegal_d;
`ifdef SPAM_AMODE_INDEXED_EN
  logic idx_n_q, idx_n_d;
`endif

  amode_e lk_amode;
  logic   lk_illegal;

  amode_lookup #(
    .CTRL_W   (CTRL_W),
    .REG_MASK (REG_MASK),
    .DIR_MASK (DIR_MASK),
    .PC_MASK  (PC_MASK)
`ifdef SPAM_AMODE_INDEXED_EN
    , .IDX_MASK (IDX_MASK)
`endif
  ) u_lookup (
    .code_i    (ctrl_d),
    .amode_o   (lk_amode),
    .illegal_o (lk_illegal)
  );

  // A FETCH/EXEC step completes only once the wait count has expired and memory is ready.
  assign phase_done = (wait_q == WAIT_MAX) && mem_rdy;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    exec_d  = exec_q;
    ctrl_d  = ctrl_q;
    unique case (state_q)
      PH_FETCH: begin
        if (phase_done) begin
          state_d = PH_DECODE;
          wait_d  = '0;
          ctrl_d  = ctrl;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + 3'd1;
        end
      end
      PH_DECODE: begin
        state_d = PH_EXEC;
        wait_d  = '0;
        exec_d  = '0;
      end
      PH_EXEC: begin
        if (phase_done) begin
          wait_d = '0;
          if (exec_q == EXEC_LAST) begin
            state_d = PH_FETCH;
            exec_d  = '0;
          end else begin
            exec_d = exec_q + 2'd1;
          end
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + 3'd1;
        end
      end
      default: state_d = PH_FETCH;
    endcase
  end

  // Enables are decoded from the next state so they switch on the same edge as the phase.
  always_comb begin
    pc_n_d    = 1'b1;
    reg_n_d   = 1'b1;
    dir_n_d   = 1'b1;
    illegal_d = 1'b0;
`ifdef SPAM_AMODE_INDEXED_EN
    idx_n_d   = 1'b1;
`endif
    if (state_d == PH_FETCH) begin
      pc_n_d = 1'b0;
    end else begin
      illegal_d = lk_illegal;
      case (lk_amode)
        AM_REG:  reg_n_d = 1'b0;
        AM_DIR:  dir_n_d = 1'b0;
`ifdef SPAM_AMODE_INDEXED_EN
        AM_IDX:  idx_n_d = 1'b0;
`endif
        default: pc_n_d  = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mr) begin
      state_q   <= PH_FETCH;
      wait_q    <= '0;
      exec_q    <= '0;
      ctrl_q    <= '0;
      pf_q      <= 1'b1;
      pd_q      <= 1'b0;
      pe_q      <= 1'b0;
      npf_q     <= 1'b0;
      pc_n_q    <= 1'b0;
      reg_n_q   <= 1'b1;
      dir_n_q   <= 1'b1;
      illegal_q <= 1'b0;
`ifdef SPAM_AMODE_INDEXED_EN
      idx_n_q   <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      exec_q    <= exec_d;
      ctrl_q    <= ctrl_d;
      pf_q      <= (state_d == PH_FETCH);
      pd_q      <= (state_d == PH_DECODE);
      pe_q      <= (state_d == PH_EXEC);
      npf_q     <= (state_d != PH_FETCH);
      pc_n_q    <= pc_n_d;
      reg_n_q   <= reg_n_d;
      dir_n_q   <= dir_n_d;
      illegal_q <= illegal_d;
`ifdef SPAM_AMODE_INDEXED_EN
      idx_n_q   <= idx_n_d;
`endif
    end
  end

  assign phaseFetch         = pf_q;
  assign phaseDecode        = pd_q;
  assign phaseExec          = pe_q;
  assign _phaseFetch        = npf_q;
  assign _addrmode_pc       = pc_n_q;
  assign _addrmode_register = reg_n_q;
  assign _addrmode_direct   = dir_n_q;
  assign illegal_mode       = illegal_q;
`ifdef SPAM_AMODE_INDEXED_EN
  assign _addrmode_indexed  = idx_n_q;
`endif

endmodule

// File: tb/tb_memory_address_sequencer.sv
// Two sequencer instances (default timing; 2 wait states with 2 exec phases)
// checked every cycle against a cycle-count model of the phase rules.
module tb_memory_address_sequencer;

  logic       clk = 1'b0;
  logic       mr_s = 1'b1;
  logic [2:0] ctrl_s = '0;
  logic       rdy_s = 1'b1;

  logic       pf[2], pd[2], pe[2], npf[2];
  logic       pc_n[2], reg_n[2], dir_n[2], idx_n[2], ill[2];
  logic [2:0] cq[2];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase, cycles spent in current step, exec index, latched code.
  int         m_ph[2], m_el[2], m_ex[2];
  logic [2:0] m_cq[2];
  int         ws_of[2] = '{0, 2};
  int         ec_of[2] = '{1, 2};
  logic [7:0] reg_mask = 8'b0000_0101;
  logic [7:0] dir_mask = 8'b0111_0000;
  logic [7:0] pc_mask  = 8'b0000_0010;
  logic [7:0] idx_mask = 8'b1000_0000;

  always #5 clk = ~clk;

  memory_address_sequencer u_dut0 (
    .clk(clk), .mr(mr_s), .ctrl(ctrl_s), .mem_rdy(rdy_s),
    .phaseFetch(pf[0]), .phaseDecode(pd[0]), .phaseExec(pe[0]), ._phaseFetch(npf[0]),
    ._addrmode_pc(pc_n[0]), ._addrmode_register(reg_n[0]), ._addrmode_direct(dir_n[0]),
`ifdef SPAM_AMODE_INDEXED_EN
    ._addrmode_indexed(idx_n[0]),
`endif
    .illegal_mode(ill[0]), .ctrl_q(cq[0])
  );

  memory_address_sequencer #(.EXEC_CYCLES(2), .WAIT_STATES(2)) u_dut1 (
    .clk(clk), .mr(mr_s), .ctrl(ctrl_s), .mem_rdy(rdy_s),
    .phaseFetch(pf[1]), .phaseDecode(pd[1]), .phaseExec(pe[1]), ._phaseFetch(npf[1]),
    ._addrmode_pc(pc_n[1]), ._addrmode_register(reg_n[1]), ._addrmode_direct(dir_n[1]),
`ifdef SPAM_AMODE_INDEXED_EN
    ._addrmode_indexed(idx_n[1]),
`endif
    .illegal_mode(ill[1]), .ctrl_q(cq[1])
  );

`ifndef SPAM_AMODE_INDEXED_EN
  assign idx_n[0] = 1'b1;
  assign idx_n[1] = 1'b1;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic model_tick(input int d);
    if (mr_s) begin
      m_ph[d] = 0; m_el[d] = 0; m_ex[d] = 0; m_cq[d] = '0;
    end else if (m_ph[d] == 0) begin
      if (m_el[d] >= ws_of[d] && rdy_s) begin
        m_ph[d] = 1; m_el[d] = 0; m_cq[d] = ctrl_s;
      end else m_el[d]++;
    end else if (m_ph[d] == 1) begin
      m_ph[d] = 2; m_el[d] = 0; m_ex[d] = 0;
    end else begin
      if (m_el[d] >= ws_of[d] && rdy_s) begin
        m_el[d] = 0;
        if (m_ex[d] == ec_of[d] - 1) m_ph[d] = 0;
        else m_ex[d]++;
      end else m_el[d]++;
    end
  endtask

  task automatic check_dut(input int d);
    logic [3:0] e_ph, g_ph, e_am, g_am;
    logic       e_ill;
    e_ph  = {m_ph[d] == 0, m_ph[d] == 1, m_ph[d] == 2, m_ph[d] != 0};
    e_ill = 1'b0;
    e_am  = 4'b0111;  // {pc, reg, dir, idx}, active low
    if (m_ph[d] != 0) begin
      if (reg_mask[m_cq[d]])      e_am = 4'b1011;
      else if (dir_mask[m_cq[d]]) e_am = 4'b1101;
`ifdef SPAM_AMODE_INDEXED_EN
      else if (idx_mask[m_cq[d]]) e_am = 4'b1110;
`endif
      else e_ill = !pc_mask[m_cq[d]];
    end
    g_ph = {pf[d], pd[d], pe[d], npf[d]};
    g_am = {pc_n[d], reg_n[d], dir_n[d], idx_n[d]};
    check_val($sformatf("d%0d_phase", d), 32'(g_ph), 32'(e_ph));
    check_val($sformatf("d%0d_amode", d), 32'(g_am), 32'(e_am));
    check_val($sformatf("d%0d_illegal", d), 32'(ill[d]), 32'(e_ill));
    check_val($sformatf("d%0d_ctrl_q", d), 32'(cq[d]), 32'(m_cq[d]));
    check_val($sformatf("d%0d_onehot", d), 32'($countones(~g_am)), 32'd1);
  endtask

  task automatic step(input logic r, input logic [2:0] c, input logic rdy);
    mr_s = r; ctrl_s = c; rdy_s = rdy;
    @(posedge clk);
    model_tick(0);
    model_tick(1);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  int  last[2], per[2];
  logic prev[2];
  bit  hit;

  initial begin
    @(negedge clk);
    step(1'b1, 3'd0, 1'b1);
    step(1'b1, 3'd0, 1'b1);

    // Free run through a set of control codes
    for (int i = 0; i < 9; i++) step(1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 3'd4, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 3'd1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 3'd3, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 3'd7, 1'b1);

    // Stall at the end of FETCH with ctrl wandering; value on the exit edge is latched
    step(1'b1, 3'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 3'(i), 1'b0);
    step(1'b0, 3'd5, 1'b1);
    check_val("stall_latch", 32'(cq[0]), 32'd5);
    for (int i = 0; i < 6; i++) step(1'b0, 3'd6, 1'b1);

    // Instruction period measured from DECODE to DECODE on the outputs
    step(1'b1, 3'd0, 1'b1);
    for (int d = 0; d < 2; d++) begin last[d] = -1; per[d] = 0; prev[d] = 1'b0; end
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 3'd2, 1'b1);
      for (int d = 0; d < 2; d++) begin
        if (pd[d] && !prev[d]) begin
          if (last[d] >= 0 && per[d] == 0) per[d] = i - last[d];
          last[d] = i;
        end
        prev[d] = pd[d];
      end
    end
    check_val("d0_period", 32'(per[0]), 32'd3);
    check_val("d1_period", 32'(per[1]), 32'd10);

    // Reset asserted during the second EXEC phase of the slow instance
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (m_ph[1] == 2 && m_ex[1] == 1) hit = 1'b1;
      else step(1'b0, 3'd4, 1'b1);
    end
    check_val("reach_exec2", 32'(hit), 32'd1);
    step(1'b1, 3'd4, 1'b1);
    check_val("mr_exec_fetch", 32'(pf[1]), 32'd1);
    check_val("mr_exec_pc", 32'(pc_n[1]), 32'd0);
    check_val("mr_exec_ctrl_q", 32'(cq[1]), 32'd0);

    // Randomized traffic with occasional resets and memory stalls
    for (int i = 0; i < 2000; i++)
      step($urandom_range(63) == 0, 3'($urandom_range(7)), $urandom_range(3) != 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
